// File: rtl/req_ack_responder.sv
// Responder side of a single-bit req/ack handshake. Each request is acked or nacked
// one cycle later. Accepted payloads are queued for a valid/ready consumer.
module req_ack_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     ack,
  output logic                     nack,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ack_cnt,
  output logic [CNT_W-1:0]         nack_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_NACK = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [LVL_W-1:0]    level_q;
  logic [CNT_W-1:0]    ack_cnt_q;
  logic [CNT_W-1:0]    nack_cnt_q;
  logic                pop;
  logic                space;
  logic                push;

  // Handshake: req is sampled on every rising edge and answered exactly one edge
  // later with ack (payload queued) or nack (queue full, payload dropped). The
  // consumer port pops on any edge where out_valid and out_ready are both high.
  assign pop   = out_valid && out_ready;
  assign space = (level_q < LVL_W'(DEPTH)) || pop;
  assign push  = req && space;

  // Response FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM: next state depends only on this edge's request and space
  always_comb begin
    state_d = ST_IDLE;
    if (req) begin
      state_d = space ? ST_ACK : ST_NACK;
    end
  end

  // Response FSM: outputs
  always_comb begin
    ack  = 1'b0;
    nack = 1'b0;
    case (state_q)
      ST_ACK:  ack  = 1'b1;
      ST_NACK: nack = 1'b1;
      default: begin
        ack  = 1'b0;
        nack = 1'b0;
      end
    endcase
  end

  // Payload storage is not reset; only pointers and occupancy define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= req_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Statistics saturate at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_q  <= '0;
      nack_cnt_q <= '0;
    end else begin
      if (state_d == ST_ACK && ack_cnt_q != '1) begin
        ack_cnt_q <= ack_cnt_q + CNT_W'(1);
      end
      if (state_d == ST_NACK && nack_cnt_q != '1) begin
        nack_cnt_q <= nack_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = level_q;
  assign ack_cnt   = ack_cnt_q;
  assign nack_cnt  = nack_cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: vector table plus hand-written sequences for
// asynchronous mid-cycle reset and counter saturation on a CNT_W=3 instance.
module tb_req_ack_responder;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [7:0] req_data;
  logic       out_ready;

  logic       ack;
  logic       nack;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [7:0] ack_cnt;
  logic [7:0] nack_cnt;

  logic       s_ack;
  logic       s_nack;
  logic       s_out_valid;
  logic [7:0] s_out_data;
  logic [2:0] s_level;
  logic [2:0] s_ack_cnt;
  logic [2:0] s_nack_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         rst;
    bit         req;
    logic [7:0] data;
    bit         ready;
    bit         e_ack;
    bit         e_nack;
    int         e_level;
    int         e_ackc;
    int         e_nackc;
  } vec_t;

  vec_t tbl[$];

  req_ack_responder #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .nack      (nack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .ack_cnt   (ack_cnt),
    .nack_cnt  (nack_cnt)
  );

  req_ack_responder #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (s_ack),
    .nack      (s_nack),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .out_ready (out_ready),
    .level     (s_level),
    .ack_cnt   (s_ack_cnt),
    .nack_cnt  (s_nack_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // concurrent properties
  a_resp: assert property (@(posedge clk) disable iff (!rst_n) req |=> (ack ^ nack))
    else begin errors++; $display("FAIL a_resp: req not answered by exactly one of ack/nack"); end
  a_idle: assert property (@(posedge clk) disable iff (!rst_n) !req |=> !(ack || nack))
    else begin errors++; $display("FAIL a_idle: response without request"); end
  a_lvl: assert property (@(posedge clk) disable iff (!rst_n) level <= 3'd4)
    else begin errors++; $display("FAIL a_lvl: level=%0d exceeds 4", level); end
  a_x: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req))
    else begin errors++; $display("FAIL a_x: req unknown"); end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit rq, input int d, input bit rdy,
                              input bit ea, input bit en, input int el, input int eac,
                              input int enc);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d[7:0]; v.ready = rdy;
    v.e_ack = ea; v.e_nack = en; v.e_level = el; v.e_ackc = eac; v.e_nackc = enc;
    return v;
  endfunction

  // called at a negedge; returns at the negedge after reset is released
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req = 1'b0;
    out_ready = 1'b0;
    #1;
    chk({tag, "_rst_ack"}, int'(ack), 0);
    chk({tag, "_rst_nack"}, int'(nack), 0);
    chk({tag, "_rst_level"}, int'(level), 0);
    chk({tag, "_rst_valid"}, int'(out_valid), 0);
    chk({tag, "_rst_ackc"}, int'(ack_cnt), 0);
    chk({tag, "_rst_nackc"}, int'(nack_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver + scoreboard: drive at negedge, score any pop, check after the next edge
  task automatic run_vec(input vec_t v, input string tag);
    if (v.rst) do_reset(tag);
    req = v.req;
    req_data = v.data;
    out_ready = v.ready;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_pop_unexpected"}, 1, 0);
      end else begin
        chk({tag, "_pop_data"}, int'(out_data), int'(exp_q.pop_front()));
      end
    end
    if (v.e_ack) exp_q.push_back(v.data);
    @(negedge clk);
    chk({tag, "_ack"}, int'(ack), int'(v.e_ack));
    chk({tag, "_nack"}, int'(nack), int'(v.e_nack));
    chk({tag, "_level"}, int'(level), v.e_level);
    chk({tag, "_valid"}, int'(out_valid), (v.e_level != 0) ? 1 : 0);
    chk({tag, "_ackc"}, int'(ack_cnt), v.e_ackc);
    chk({tag, "_nackc"}, int'(nack_cnt), v.e_nackc);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    req_data = 8'h00;
    out_ready = 1'b0;

    // request pulses with consumer always ready
    tbl.push_back(mk(1, 1, 'h11, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 'h22, 1, 1, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 'h33, 1, 1, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 0, 0, 3, 0));
    // fill to full with consumer stalled, then drain
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(i == 1, 1, i, 0, 1, 0, i, i, 0));
    tbl.push_back(mk(0, 1, 5, 0, 0, 1, 4, 4, 1));
    tbl.push_back(mk(0, 1, 6, 0, 0, 1, 4, 4, 2));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3 - k, 4, 2));
    // full FIFO with a simultaneous pop still accepts
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(i == 1, 1, i, 0, 1, 0, i, i, 0));
    tbl.push_back(mk(0, 1, 'hA5, 1, 1, 0, 4, 5, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3 - k, 5, 0));
    // pointer wrap-around with continuous accept and pop
    for (int i = 0; i < 10; i++) tbl.push_back(mk(i == 0, 1, i, 1, 1, 0, 1, i + 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 10, 0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));
    chk("table_queue_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a cycle with an ack pending
    do_reset("mid");
    run_vec(mk(0, 1, 7, 0, 1, 0, 1, 1, 0), "mid_a");
    run_vec(mk(0, 1, 8, 0, 1, 0, 2, 2, 0), "mid_b");
    run_vec(mk(0, 1, 9, 0, 1, 0, 3, 3, 0), "mid_c");
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("mid_async_ack", int'(ack), 0);
    chk("mid_async_nack", int'(nack), 0);
    chk("mid_async_level", int'(level), 0);
    chk("mid_async_valid", int'(out_valid), 0);
    chk("mid_async_ackc", int'(ack_cnt), 0);
    chk("mid_async_nackc", int'(nack_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    chk("mid_hold_ack", int'(ack), 0);
    rst_n = 1'b1;
    run_vec(mk(0, 1, 'h42, 0, 1, 0, 1, 1, 0), "mid_after");
    run_vec(mk(0, 0, 0, 1, 0, 0, 0, 1, 0), "mid_drain");

    // saturation on the narrow-counter instance
    do_reset("sat");
    for (int k = 1; k <= 9; k++) begin
      run_vec(mk(0, 1, 'h50 + k, 1, 1, 0, 1, k, 0), $sformatf("sat%0d", k));
      chk($sformatf("sat%0d_s_ackc", k), int'(s_ack_cnt), (k < 7) ? k : 7);
      chk($sformatf("sat%0d_s_nackc", k), int'(s_nack_cnt), 0);
      chk($sformatf("sat%0d_s_ack", k), int'(s_ack), 1);
    end
    run_vec(mk(0, 0, 0, 1, 0, 0, 0, 9, 0), "sat_end");
    chk("sat_end_s_ackc", int'(s_ack_cnt), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
